// File: rtl/sd_read_seq_pkg.sv
// sd_read_seq_pkg: descriptor, state and status types shared by the SD read sequencer
package sd_read_seq_pkg;
    localparam int SECTOR_SHIFT = 9;

    typedef struct packed {
        logic [31:0] dstaddr;
        logic [31:0] sector;
        logic [22:0] count;
        logic [3:0]  tag;
    } desc_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_CMPL
    } state_t;

    typedef enum logic [1:0] {
        ST_OK      = 2'd0,
        ST_ERR     = 2'd1,
        ST_ABORT   = 2'd2,
        ST_TIMEOUT = 2'd3
    } status_t;

    function automatic logic [22:0] chunk_of(input logic [22:0] remaining, input logic [22:0] limit);
        return remaining < limit ? remaining : limit;
    endfunction
endpackage

// File: rtl/sd_read_seq_desc_fifo.sv
// sd_read_seq_desc_fifo: synchronous descriptor FIFO with registered count and a whole-queue flush
module sd_read_seq_desc_fifo
    import sd_read_seq_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic  aclk,
    input  logic  aresetn,
    input  logic  flush,
    input  logic  push,
    input  logic  pop,
    input  desc_t din,
    output desc_t dout,
    output logic  full,
    output logic  empty
);
    localparam int AW = $clog2(DEPTH);

    desc_t         mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          do_push, do_pop;

    assign full    = count == (AW+1)'(DEPTH);
    assign empty   = count == '0;
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign dout    = mem[rd_ptr];

    // pointers and occupancy; flush discards everything queued
    always_ff @(posedge aclk or negedge aresetn)
        if (!aresetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end

    // descriptor storage
    always_ff @(posedge aclk)
        if (do_push) mem[wr_ptr] <= din;
endmodule

// File: rtl/sd_read_sequencer.sv
// sd_read_sequencer: splits queued SD read descriptors into controller-sized runs and reports completions.
// Build macro SD_READ_SEQ_TIMEOUT_EN adds a watchdog that ends a stuck run with TIMEOUT status.
module sd_read_sequencer
    import sd_read_seq_pkg::*;
#(
    parameter int DEPTH          = 4,
    parameter int CHUNK_SECTORS  = 128,
    parameter int TIMEOUT_CYCLES = 1 << 24
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        desc_valid,
    output logic        desc_ready,
    input  logic [31:0] desc_dstaddr,
    input  logic [31:0] desc_sector,
    input  logic [22:0] desc_count,
    input  logic [3:0]  desc_tag,
    input  logic        abort,
    output logic        ctl_start,
    output logic [31:0] ctl_dstaddr,
    output logic [31:0] ctl_startsector,
    output logic [22:0] ctl_sectornum,
    input  logic        ctl_busy,
    input  logic        ctl_err,
    output logic        ctl_reset,
    output logic        cmpl_valid,
    input  logic        cmpl_ready,
    output logic [3:0]  cmpl_tag,
    output logic [1:0]  cmpl_status,
    output logic [22:0] cmpl_sectors
);
    localparam logic [22:0] CHUNK = 23'(CHUNK_SECTORS);

    state_t      state, state_nxt;
    status_t     status_nxt;
    desc_t       head;
    logic        fifo_full, fifo_empty, pop, running, chunk_ok, enter_cmpl;
    logic [22:0] remaining, rem_left;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || CHUNK_SECTORS < 1 || CHUNK_SECTORS > (1 << 22)
        || TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("sd_read_sequencer: parameter out of range");
    end

    sd_read_seq_desc_fifo #(.DEPTH(DEPTH)) u_fifo (
        .aclk    (aclk),
        .aresetn (aresetn),
        .flush   (abort),
        .push    (desc_valid && desc_ready),
        .pop     (pop),
        .din     ({desc_dstaddr, desc_sector, desc_count, desc_tag}),
        .dout    (head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign desc_ready = running && !fifo_full && !abort;
    assign ctl_start  = state == S_ISSUE;
    assign cmpl_valid = state == S_CMPL;
    assign rem_left   = remaining - ctl_sectornum;
    assign chunk_ok   = state == S_WAIT_DONE && !ctl_busy && !ctl_err;
    assign enter_cmpl = state_nxt == S_CMPL && state != S_CMPL;

`ifdef SD_READ_SEQ_TIMEOUT_EN
    logic [31:0] wd_count;
    logic        wd_expired;

    assign wd_expired = ((state == S_WAIT_BUSY && !ctl_busy) || (state == S_WAIT_DONE && ctl_busy))
                        && wd_count == 32'(TIMEOUT_CYCLES - 1);

    // watchdog restarts on every state change, so each busy phase is timed separately
    always_ff @(posedge aclk or negedge aresetn)
        if (!aresetn) wd_count <= '0;
        else wd_count <= state_nxt != state ? '0 : wd_count + 32'd1;
`endif

    // next state and the status a run finishes with
    always_comb begin
        state_nxt  = state;
        status_nxt = ST_OK;
        pop        = 1'b0;
        case (state)
            S_IDLE: if (!fifo_empty && !abort) begin
                pop       = 1'b1;
                state_nxt = head.count == '0 ? S_CMPL : S_ISSUE;
            end
            S_ISSUE:     state_nxt = S_WAIT_BUSY;
            S_WAIT_BUSY: state_nxt = ctl_busy ? S_WAIT_DONE : S_WAIT_BUSY;
            S_WAIT_DONE: if (!ctl_busy) begin
                state_nxt  = ctl_err || rem_left == '0 || abort ? S_CMPL : S_ISSUE;
                status_nxt = ctl_err ? ST_ERR : rem_left == '0 ? ST_OK : ST_ABORT;
            end
            S_CMPL:      state_nxt = cmpl_ready ? S_IDLE : S_CMPL;
            default:     state_nxt = S_IDLE;
        endcase
`ifdef SD_READ_SEQ_TIMEOUT_EN
        if (wd_expired) begin
            state_nxt  = S_CMPL;
            status_nxt = ST_TIMEOUT;
        end
`endif
    end

    // state register
    always_ff @(posedge aclk or negedge aresetn)
        if (!aresetn) state <= S_IDLE;
        else state <= state_nxt;

    // run bookkeeping: load on pop, advance after each clean chunk, latch status and pulse reset on completion entry
    always_ff @(posedge aclk or negedge aresetn)
        if (!aresetn) begin
            running         <= 1'b0;
            ctl_reset       <= 1'b0;
            ctl_dstaddr     <= '0;
            ctl_startsector <= '0;
            ctl_sectornum   <= '0;
            remaining       <= '0;
            cmpl_tag        <= '0;
            cmpl_status     <= '0;
            cmpl_sectors    <= '0;
        end else begin
            running   <= 1'b1;
            ctl_reset <= enter_cmpl && (status_nxt == ST_ERR || status_nxt == ST_TIMEOUT);
            if (enter_cmpl) cmpl_status <= status_nxt;
            if (pop) begin
                ctl_dstaddr     <= head.dstaddr;
                ctl_startsector <= head.sector;
                ctl_sectornum   <= chunk_of(head.count, CHUNK);
                remaining       <= head.count;
                cmpl_tag        <= head.tag;
                cmpl_sectors    <= '0;
            end else if (chunk_ok) begin
                ctl_dstaddr     <= ctl_dstaddr + (32'(ctl_sectornum) << SECTOR_SHIFT);
                ctl_startsector <= ctl_startsector + 32'(ctl_sectornum);
                remaining       <= rem_left;
                cmpl_sectors    <= cmpl_sectors + ctl_sectornum;
                if (state_nxt == S_ISSUE) ctl_sectornum <= chunk_of(rem_left, CHUNK);
            end
        end
endmodule

// File: tb/tb_sd_read_sequencer.sv
// tb_sd_read_sequencer: randomized and directed checks of the SD read sequencer against a chunking model
module tb_sd_read_sequencer;
    logic        aclk = 1'b0, aresetn = 1'b0;
    logic        desc_valid = 1'b0, desc_ready;
    logic [31:0] desc_dstaddr = '0, desc_sector = '0;
    logic [22:0] desc_count = '0;
    logic [3:0]  desc_tag = '0;
    logic        abort = 1'b0;
    logic        ctl_start, ctl_reset, ctl_busy, ctl_err;
    logic [31:0] ctl_dstaddr, ctl_startsector;
    logic [22:0] ctl_sectornum;
    logic        cmpl_valid, cmpl_ready = 1'b0;
    logic [3:0]  cmpl_tag;
    logic [1:0]  cmpl_status;
    logic [22:0] cmpl_sectors;

    int nvec = 0, nerr = 0;
    int n_start = 0, n_start_hi = 0, n_rst = 0, n_cmpl_hi = 0;
    int err_at = 0, lat_cfg = 1, dur_cfg = 3;
    logic [86:0] starts[$], exp_q[$];

    always #5 aclk = ~aclk;

    sd_read_sequencer dut (
        .aclk(aclk), .aresetn(aresetn),
        .desc_valid(desc_valid), .desc_ready(desc_ready),
        .desc_dstaddr(desc_dstaddr), .desc_sector(desc_sector), .desc_count(desc_count), .desc_tag(desc_tag),
        .abort(abort),
        .ctl_start(ctl_start), .ctl_dstaddr(ctl_dstaddr), .ctl_startsector(ctl_startsector),
        .ctl_sectornum(ctl_sectornum), .ctl_busy(ctl_busy), .ctl_err(ctl_err), .ctl_reset(ctl_reset),
        .cmpl_valid(cmpl_valid), .cmpl_ready(cmpl_ready), .cmpl_tag(cmpl_tag),
        .cmpl_status(cmpl_status), .cmpl_sectors(cmpl_sectors)
    );

    // datapath stand-in: logs each start, then runs busy for a while and reports an error on the planned run
    initial begin
        ctl_busy = 1'b0;
        ctl_err  = 1'b0;
        forever begin
            @(negedge aclk);
            ctl_err = 1'b0;
            if (ctl_start === 1'b1) begin
                starts.push_back({ctl_dstaddr, ctl_startsector, ctl_sectornum});
                n_start++;
                repeat (lat_cfg) @(negedge aclk);
                ctl_busy = 1'b1;
                repeat (dur_cfg) @(negedge aclk);
                ctl_busy = 1'b0;
                ctl_err  = n_start == err_at;
            end
        end
    end

    always @(negedge aclk) begin
        if (ctl_start === 1'b1) n_start_hi++;
        if (ctl_reset === 1'b1) n_rst++;
        if (cmpl_valid === 1'b1) n_cmpl_hi++;
    end

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] d, input logic [31:0] s, input logic [22:0] c, input logic [3:0] t);
        int n = 0;
        desc_dstaddr = d;
        desc_sector  = s;
        desc_count   = c;
        desc_tag     = t;
        desc_valid   = 1'b1;
        while (desc_ready !== 1'b1 && n < 500) begin
            @(negedge aclk);
            n++;
        end
        check("push_accept", n < 500, 1);
        @(negedge aclk);
        desc_valid = 1'b0;
    endtask

    task automatic wait_cmpl(input string tag, input logic [3:0] t, input logic [1:0] st, input logic [22:0] sec);
        int n = 0;
        while (cmpl_valid !== 1'b1 && n < 5000) begin
            @(negedge aclk);
            n++;
        end
        check({tag, "_seen"}, n < 5000, 1);
        check({tag, "_ctlreset"}, ctl_reset, st == 2'd1 || st == 2'd3);
        check({tag, "_fields"}, {cmpl_tag, cmpl_status, cmpl_sectors}, {t, st, sec});
        repeat ($urandom_range(0, 2)) @(negedge aclk);
        check({tag, "_hold"}, {cmpl_valid, cmpl_tag, cmpl_status, cmpl_sectors}, {1'b1, t, st, sec});
        cmpl_ready = 1'b1;
        @(negedge aclk);
        cmpl_ready = 1'b0;
        check({tag, "_drop"}, cmpl_valid, 0);
    endtask

    // model: walk the descriptor chunk by chunk, stopping at the chunk the datapath fails
    task automatic run_one(input string tag, input logic [31:0] d, input logic [31:0] s, input logic [22:0] c,
                           input logic [3:0] t, input int err_k);
        logic [31:0] a, sc;
        logic [22:0] r, n, done;
        logic [1:0]  st;
        int          k, r0, h0;
        a = d; sc = s; r = c; done = '0; st = 2'd0; k = 0;
        exp_q.delete();
        starts.delete();
        while (r != 0) begin
            n = r < 23'd128 ? r : 23'd128;
            exp_q.push_back({a, sc, n});
            k++;
            if (k == err_k) begin
                st = 2'd1;
                break;
            end
            done += n;
            a    += 32'(n) * 32'd512;
            sc   += 32'(n);
            r    -= n;
        end
        r0 = n_rst;
        h0 = n_start_hi;
        err_at = err_k == 0 ? 0 : n_start + err_k;
        push(d, s, c, t);
        wait_cmpl(tag, t, st, done);
        repeat (2) @(negedge aclk);
        check({tag, "_nstarts"}, starts.size(), exp_q.size());
        foreach (exp_q[i]) check({tag, "_chunk"}, i < starts.size() ? starts[i] : '0, exp_q[i]);
        check({tag, "_start_cycles"}, n_start_hi - h0, exp_q.size());
        check({tag, "_ctlreset_count"}, n_rst - r0, st == 2'd1);
        err_at = 0;
    endtask

    initial begin
        int n, h0, r0, c0, cnt, nch, ek;
        repeat (2) @(negedge aclk);
        check("reset_outputs", {desc_ready, ctl_start, ctl_reset, cmpl_valid, ctl_dstaddr, ctl_startsector,
                                ctl_sectornum, cmpl_tag, cmpl_status, cmpl_sectors}, 0);
        aresetn = 1'b1;
        @(negedge aclk);
        check("reset_ready", desc_ready, 1);

        run_one("example", 32'h8000_0000, 32'd100, 23'd300, 4'd5, 0);
        check("example_last", starts[2], {32'h8002_0000, 32'd356, 23'd44});

        for (int it = 0; it < 10; it++) begin
            cnt = it == 0 ? 128 : it == 1 ? 129 : it == 2 ? 1 : $urandom_range(1, 700);
            nch = (cnt + 127) / 128;
            ek  = $urandom_range(0, 2) == 0 ? $urandom_range(1, nch) : 0;
            lat_cfg = $urandom_range(0, 3);
            dur_cfg = $urandom_range(1, 5);
            run_one($sformatf("rnd%0d", it), it == 3 ? 32'hFFFF_FE00 : $urandom, $urandom, 23'(cnt),
                    4'($urandom_range(0, 15)), ek);
        end
        lat_cfg = 1;
        dur_cfg = 3;

        starts.delete();
        r0 = n_rst;
        err_at = n_start + 2;
        push(32'h1000_0000, 32'd50, 23'd300, 4'd7);
        push(32'h2000_0000, 32'd7, 23'd10, 4'd8);
        wait_cmpl("err_a", 4'd7, 2'd1, 23'd128);
        wait_cmpl("err_b", 4'd8, 2'd0, 23'd10);
        check("err_nstarts", starts.size(), 3);
        check("err_chunk2", starts[1], {32'h1001_0000, 32'd178, 23'd128});
        check("err_next", starts[2], {32'h2000_0000, 32'd7, 23'd10});
        check("err_ctlreset_count", n_rst - r0, 1);
        err_at = 0;

        h0 = n_start_hi;
        push(32'h0, 32'h0, 23'd0, 4'd1);
        repeat (3) @(negedge aclk);
        check("zero_pending", cmpl_valid, 1);
        for (int i = 2; i < 6; i++) push(32'h0, 32'(i), 23'd0, 4'(i));
        check("full_ready_low", desc_ready, 0);
        repeat (3) @(negedge aclk);
        check("full_ready_still_low", desc_ready, 0);
        wait_cmpl("zero1", 4'd1, 2'd0, 23'd0);
        push(32'h0, 32'h6, 23'd0, 4'd6);
        for (int i = 2; i < 7; i++) wait_cmpl($sformatf("zero%0d", i), 4'(i), 2'd0, 23'd0);
        check("zero_no_start", n_start_hi - h0, 0);

        starts.delete();
        dur_cfg = 30;
        push(32'h4000_0000, 32'd0, 23'd300, 4'd9);
        push(32'h4100_0000, 32'd20, 23'd10, 4'd10);
        push(32'h4200_0000, 32'd5, 23'd10, 4'd11);
        n = 0;
        while (starts.size() == 0 && n < 100) begin
            @(negedge aclk);
            n++;
        end
        abort = 1'b1;
        @(negedge aclk);
        check("abort_ready_low", desc_ready, 0);
        wait_cmpl("abort", 4'd9, 2'd2, 23'd128);
        abort = 1'b0;
        h0 = n_start_hi;
        c0 = n_cmpl_hi;
        repeat (40) @(negedge aclk);
        check("abort_no_start", n_start_hi - h0, 0);
        check("abort_no_cmpl", n_cmpl_hi - c0, 0);
        check("abort_chunks", starts.size(), 1);
        check("abort_ready_back", desc_ready, 1);
        dur_cfg = 3;

        starts.delete();
        push(32'h5000_0000, 32'd0, 23'd300, 4'd12);
        n = 0;
        while (starts.size() == 0 && n < 100) begin
            @(negedge aclk);
            n++;
        end
        r0 = n_rst;
        aresetn = 1'b0;
        @(negedge aclk);
        check("midrst_outputs", {desc_ready, ctl_start, ctl_reset, cmpl_valid, ctl_dstaddr, ctl_sectornum,
                                 cmpl_sectors}, 0);
        aresetn = 1'b1;
        c0 = n_cmpl_hi;
        repeat (60) @(negedge aclk);
        check("midrst_no_cmpl", n_cmpl_hi - c0, 0);
        check("midrst_no_ctlreset", n_rst - r0, 0);
        check("midrst_ready", desc_ready, 1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
